alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Parametrised successor to the single-cycle datapath ALU. Adds a valid/ready
//  handshake, registered results, signed ops and an iterative MUL/DIVU/REMU
//  unit. Sits between register-read and writeback. Execute stalls on in_ready.
// PARAMETERS
//  WIDTH   16  operand/result width in bits, >=4, power of two
//  SHW     $clog2(WIDTH)  shift-amount bits (derived, do not override)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation request
//  in_ready   out  1      block can accept a request
//  op         in   4      operation code (table below)
//  a          in   WIDTH  operand 1
//  b          in   WIDTH  operand 2
//  out_valid  out  1      res/zero/illegal valid
//  out_ready  in   1      consumer takes result
//  res        out  WIDTH  result
//  zero       out  1      res == 0
//  illegal    out  1      op not supported in this build
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; res=0; zero=1;
//   illegal=0; iteration counter=0. Reset mid-op aborts it. No result appears.
//  Ops: 0 ADD, 1 SUB, 2 NOT a, 3 SLL, 4 SRL, 5 AND, 6 OR, 7 SLTU,
//   8 SLT (signed), 9 XOR, 10 SRA, 11 MUL (low WIDTH bits), 12 DIVU, 13 REMU,
//   14-15 illegal.
//  Arithmetic: ADD/SUB wrap modulo 2^WIDTH. Shifts use b[SHW-1:0] only.
//   SLT/SLTU give 1 or 0 in res.
//  Div by zero: DIVU -> all ones, REMU -> a. No other flag is raised.
//  FSM IDLE -> (in_valid, single-cycle op) -> DONE
//   IDLE -> (in_valid, op 11..13) -> BUSY
//   BUSY: one shift-add or shift-subtract step per cycle. Counter 0..WIDTH-1.
//   When the counter reaches WIDTH-1, go to DONE.
//   DONE -> (out_ready) -> IDLE
//  Handshake:
//   - Accept only when in_valid && in_ready; op/a/b are captured on that edge.
//   - in_ready = (state==IDLE). No acceptance in BUSY/DONE.
//  Latency, accept at edge N:
//   - single-cycle op: out_valid=1 after edge N+1.
//   - MUL/DIVU/REMU: out_valid=1 after edge N+WIDTH+1.
//  Output hold: res/zero/illegal stable while out_valid && !out_ready.
//   - On out_valid && out_ready: out_valid=0 next cycle.
//   - res keeps its last value; it is not cleared.
//  Illegal op: 1-cycle path; res=0, zero=1, illegal=1. Not a stall.
//  Changes of a/b/op after acceptance have no effect.
// CONFIGURATION
//  ALU_MULDIV_EN defined: ops 11-13 are implemented as above.
//  ALU_MULDIV_EN undefined: ops 11-13 are treated as illegal (1 cycle, res=0,
//   illegal=1). No iteration datapath or counter is synthesised.
// TESTING (WIDTH=16)
//  1. ADD a=16'hFFFF b=16'h0002 -> res=16'h0001, zero=0; out_valid one cycle
//     after accept.
//  2. SRA a=16'h8000 b=16'h0013 -> shift 3, res=16'hF000.
//     SLT a=16'hFFFF b=16'h0001 -> res=1. SLTU on the same a/b -> res=0.
//  3. MUL a=16'd300 b=16'd300 -> res=16'h5F90, out_valid at accept+17,
//     in_ready=0 throughout.
//     DIVU 16'd100/16'd7 -> 16'd14. REMU of the same -> 16'd2.
//  4. DIVU b=0, a=16'h1234 -> res=16'hFFFF. REMU b=0 -> res=16'h1234.
//     op=14 -> res=0, zero=1, illegal=1.
//  5. out_ready low 5 cycles after a result: res/out_valid held, in_ready=0,
//     and in_valid is ignored. Raise out_ready -> next request is accepted.
//  6. Assert rst_n=0 in cycle 8 of a MUL: out_valid=0, in_ready=1 immediately.
//     After release, a fresh ADD completes normally.
//     Rerun 3/4 without ALU_MULDIV_EN -> illegal=1 in 1 cycle.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: valid/ready ALU with registered results.
// Single-cycle ops return one cycle after the operand-load cycle. MUL, DIVU
// and REMU use an iterative shift-add or shift-subtract unit that runs for
// WIDTH cycles. That unit is built only when ALU_MULDIV_EN is defined.
// Without the macro, ops 11-13 take the illegal path.
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, illegal_q, illegal_d;
  logic [WIDTH-1:0] s_res;
  logic             s_ill;
  logic             is_md;

`ifdef ALU_MULDIV_EN
  // p holds the product accumulator (MUL) or the partial remainder (DIVU/REMU).
  // x is the shifting multiplicand, or the dividend that turns into the quotient.
  // y is the shifting multiplier, or the fixed divisor.
  logic [WIDTH-1:0] p_q, p_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] p_n, x_n, y_n, md_res;
  logic [WIDTH:0]   rs;

  assign is_md = (op_q == 4'd11) || (op_q == 4'd12) || (op_q == 4'd13);

  // One iteration step. DIVU of 0 yields all ones and REMU of 0 yields a,
  // both without any special-casing.
  always_comb begin
    p_n = p_q;
    x_n = x_q;
    y_n = y_q;
    rs  = '0;
    if (op_q == 4'd11) begin
      if (y_q[0]) p_n = p_q + x_q;
      x_n = x_q << 1;
      y_n = y_q >> 1;
    end else begin
      rs  = {p_q, x_q[WIDTH-1]};
      x_n = {x_q[WIDTH-2:0], 1'b0};
      if (rs >= {1'b0, y_q}) begin
        rs     = rs - {1'b0, y_q};
        x_n[0] = 1'b1;
      end
      p_n = rs[WIDTH-1:0];
    end
    md_res = (op_q == 4'd12) ? x_n : p_n;
  end
`else
  assign is_md = 1'b0;
`endif

  // Single-cycle datapath. Every op code it does not handle is flagged illegal.
  always_comb begin
    s_res = '0;
    s_ill = 1'b0;
    case (op_q)
      4'd0:    s_res = x_q + y_q;
      4'd1:    s_res = x_q - y_q;
      4'd2:    s_res = ~x_q;
      4'd3:    s_res = x_q << y_q[SHW-1:0];
      4'd4:    s_res = x_q >> y_q[SHW-1:0];
      4'd5:    s_res = x_q & y_q;
      4'd6:    s_res = x_q | y_q;
      4'd7:    s_res = {{(WIDTH-1){1'b0}}, (x_q < y_q)};
      4'd8:    s_res = {{(WIDTH-1){1'b0}}, ($signed(x_q) < $signed(y_q))};
      4'd9:    s_res = x_q ^ y_q;
      4'd10:   s_res = WIDTH'($signed(x_q) >>> y_q[SHW-1:0]);
      default: s_ill = 1'b1;
    endcase
  end

  // Next-state and output logic. Operands are captured on accept and
  // consumed in LOAD, so later changes on a/b/op have no effect.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    x_d       = x_q;
    y_d       = y_q;
    res_d     = res_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_MULDIV_EN
    p_d       = p_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        op_d    = op;
        x_d     = a;
        y_d     = b;
`ifdef ALU_MULDIV_EN
        p_d     = '0;
        cnt_d   = '0;
`endif
        state_d = LOAD;
      end
      LOAD: if (is_md) begin
        state_d = BUSY;
      end else begin
        res_d     = s_res;
        zero_d    = (s_res == '0);
        illegal_d = s_ill;
        state_d   = DONE;
      end
`ifdef ALU_MULDIV_EN
      BUSY: begin
        p_d   = p_n;
        x_d   = x_n;
        y_d   = y_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          res_d     = md_res;
          zero_d    = (md_res == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Asserting reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      res_q     <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      p_q       <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      x_q       <= x_d;
      y_q       <= y_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_MULDIV_EN
      p_q       <= p_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=16). It honours ALU_MULDIV_EN.
module tb_alu_multicycle;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b, res;
  logic         zero, illegal;

  int npass = 0;
  int nchk  = 0;
  int tmo   = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  // Reference behaviour written as plain arithmetic on the operands.
  function automatic void model(input logic [3:0] o, input logic [W-1:0] x, y,
                                output logic [W-1:0] r, output logic ill,
                                output int lat);
    int sh;
    sh  = int'(y) % W;
    r   = '0;
    ill = 1'b0;
    lat = 1;
    case (o)
      4'd0:  r = W'(int'(x) + int'(y));
      4'd1:  r = W'(int'(x) - int'(y));
      4'd2:  r = ~x;
      4'd3:  r = W'(int'(x) * (1 << sh));
      4'd4:  r = W'(int'(x) / (1 << sh));
      4'd5:  r = x & y;
      4'd6:  r = x | y;
      4'd7:  r = (int'(x) < int'(y)) ? 1 : 0;
      4'd8:  r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd9:  r = x ^ y;
      4'd10: r = W'($signed(x) >>> sh);
      4'd11, 4'd12, 4'd13: begin
        if (MD) begin
          lat = W + 1;
          if (o == 4'd11)      r = W'(longint'(x) * longint'(y));
          else if (y == 0)     r = (o == 4'd12) ? {W{1'b1}} : x;
          else if (o == 4'd12) r = x / y;
          else                 r = x % y;
        end else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  // Pin the model to hand-computed values, then check the DUT on every cycle.
  initial begin : compare
    logic [W-1:0] r, er;
    logic         il, ez, ei, pend;
    int           lt, due, cyc;
    model(4'd0, 16'hFFFF, 16'h0002, r, il, lt);  chk("pin_add", r, 16'h0001);
    model(4'd10, 16'h8000, 16'h0013, r, il, lt); chk("pin_sra", r, 16'hF000);
    model(4'd8, 16'hFFFF, 16'h0001, r, il, lt);  chk("pin_slt", r, 16'h0001);
    model(4'd7, 16'hFFFF, 16'h0001, r, il, lt);  chk("pin_sltu", r, 16'h0000);
    model(4'd14, 16'h1234, 16'h0001, r, il, lt); chk("pin_ill14", {15'd0, il}, 16'h0001);
`ifdef ALU_MULDIV_EN
    model(4'd11, 16'd300, 16'd300, r, il, lt);   chk("pin_mul", r, 16'h5F90);
    model(4'd12, 16'd100, 16'd7, r, il, lt);     chk("pin_divu", r, 16'd14);
    model(4'd13, 16'd100, 16'd7, r, il, lt);     chk("pin_remu", r, 16'd2);
    model(4'd12, 16'h1234, 16'h0000, r, il, lt); chk("pin_div0", r, 16'hFFFF);
    model(4'd13, 16'h1234, 16'h0000, r, il, lt); chk("pin_rem0", r, 16'h1234);
`else
    model(4'd11, 16'd300, 16'd300, r, il, lt);   chk("pin_mul_ill", {15'd0, il}, 16'h0001);
`endif
    pend = 1'b0; due = 0; cyc = 0; er = '0; ez = 1'b1; ei = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend = 1'b0;
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_res", res, 16'd0);
        chk("rst_flags", {14'd0, zero, illegal}, 16'b10);
      end else if (pend) begin
        if (cyc < due) begin
          chk("busy_ready_valid", {14'd0, in_ready, out_valid}, 16'b00);
        end else begin
          chk("out_valid", {15'd0, out_valid}, 16'd1);
          chk("in_ready_done", {15'd0, in_ready}, 16'd0);
          chk("res", res, er);
          chk("zero_illegal", {14'd0, zero, illegal}, {14'd0, ez, ei});
          if (out_ready) pend = 1'b0;
        end
      end else begin
        chk("idle_ready_valid", {14'd0, in_ready, out_valid}, 16'b10);
        if (in_valid) begin
          model(op, a, b, er, ei, lt);
          if (ei) er = '0;
          ez   = (er == '0);
          due  = cyc + 1 + lt;
          pend = 1'b1;
        end
      end
    end
  end

  // Present a request with a time bound, then scramble the inputs once it is taken.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, y);
    logic acc;
    op = o; a = x; b = y; in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk);
    end
    if (!acc) begin tmo++; $display("FAIL accept_timeout op=%0d", o); end
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); got = out_valid && out_ready;
    end
    if (!got) begin tmo++; $display("FAIL result_timeout"); end
    @(posedge clk); #1;
  endtask

  typedef struct { logic [3:0] o; logic [W-1:0] x, y; } vec_t;
  vec_t vecs[$];

  initial begin : drive
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    vecs = '{
      '{4'd0, 16'hFFFF, 16'h0002}, '{4'd0, 16'h8000, 16'h8000},
      '{4'd1, 16'h0005, 16'h0007}, '{4'd2, 16'h00FF, 16'h1234},
      '{4'd3, 16'h0001, 16'h0014}, '{4'd4, 16'h8000, 16'h000F},
      '{4'd5, 16'hF0F0, 16'hFF00}, '{4'd6, 16'hF0F0, 16'h0F0F},
      '{4'd7, 16'hFFFF, 16'h0001}, '{4'd8, 16'hFFFF, 16'h0001},
      '{4'd8, 16'h0001, 16'hFFFF}, '{4'd9, 16'hAAAA, 16'hAAAA},
      '{4'd10, 16'h8000, 16'h0013}, '{4'd10, 16'h4000, 16'h0002},
      '{4'd11, 16'd300, 16'd300}, '{4'd11, 16'hFFFF, 16'hFFFF},
      '{4'd12, 16'd100, 16'd7}, '{4'd13, 16'd100, 16'd7},
      '{4'd12, 16'h1234, 16'h0000}, '{4'd13, 16'h1234, 16'h0000},
      '{4'd12, 16'hFFFF, 16'h0001}, '{4'd14, 16'h1234, 16'h5678},
      '{4'd15, 16'h0000, 16'h0000}
    };
    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].x, vecs[i].y);
      wait_done();
    end
    // Hold the result for 5 cycles while a second request waits.
    out_ready = 1'b0;
    issue(4'd0, 16'd3, 16'd4);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    op = 4'd1; a = 16'd9; b = 16'd4; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    issue(4'd1, 16'd9, 16'd4);
    wait_done();
    // Assert reset partway through a MUL, then run a fresh ADD.
    issue(4'd11, 16'd300, 16'd300);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(4'd0, 16'h1111, 16'h2222);
    wait_done();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", npass, nchk + tmo);
    $finish;
  end
endmodule
